// File: rtl/mem_arbiter.sv
// Memory arbiter: one pending slot each for CPU, PPU and refresh, sharing a
// single-outstanding-command memory controller via an IDLE/ISSUE/SETTLE/WAIT FSM.
module mem_arbiter #(
  parameter int REFRESH_INTERVAL  = 780,
  parameter int REFRESH_MAX_DEFER = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [21:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ack,
  input  logic        ppu_req,
  input  logic [21:0] ppu_addr,
  output logic [7:0]  ppu_dout,
  output logic        ppu_ack,
  output logic        mem_read_a,
  output logic        mem_read_b,
  output logic        mem_write,
  output logic        mem_refresh,
  output logic [21:0] mem_addr,
  output logic [7:0]  mem_din,
  input  logic [7:0]  mem_dout_a,
  input  logic [7:0]  mem_dout_b,
  input  logic        mem_busy,
  output logic        overrun
);

  localparam int RW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam int DW = $clog2(REFRESH_MAX_DEFER + 1);
  localparam logic [RW-1:0] RELOAD = RW'(REFRESH_INTERVAL - 1);
  localparam logic [DW-1:0] DMAX   = DW'(REFRESH_MAX_DEFER);

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, WAIT} state_t;
  typedef enum logic [1:0] {G_CPU, G_PPU, G_REF} gnt_t;

  state_t state, state_nx;
  gnt_t   gnt, gnt_nx;
  logic   grant;

  logic          cpu_pend, cpu_we_q;
  logic [21:0]   cpu_addr_q;
  logic [7:0]    cpu_din_q;
  logic          ppu_pend;
  logic [21:0]   ppu_addr_q;
  logic          ref_pend;
  logic [DW-1:0] defer;
  logic [RW-1:0] ref_cnt;

  logic cpu_take, ppu_take, cpu_eff, ppu_eff, ref_tick, done, issue;

  assign cpu_take = cpu_req && !cpu_pend;
  assign ppu_take = ppu_req && !ppu_pend;
  // An accepted request is visible to arbitration in the cycle it arrives.
  assign cpu_eff  = cpu_pend || cpu_take;
  assign ppu_eff  = ppu_pend || ppu_take;
  assign ref_tick = (ref_cnt == '0);
  assign done     = (state == WAIT) && !mem_busy;
  assign issue    = (state == ISSUE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      gnt   <= G_CPU;
    end else begin
      state <= state_nx;
      gnt   <= gnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    grant    = 1'b0;
    case (state)
      IDLE: begin
        if (!mem_busy && (cpu_eff || ppu_eff || ref_pend)) begin
          grant    = 1'b1;
          state_nx = ISSUE;
          if (ref_pend && defer == DMAX) gnt_nx = G_REF;
          else if (ppu_eff)              gnt_nx = G_PPU;
          else if (cpu_eff)              gnt_nx = G_CPU;
          else                           gnt_nx = G_REF;
        end
      end
      ISSUE:   state_nx = SETTLE;
      SETTLE:  state_nx = WAIT;
      WAIT:    if (!mem_busy) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign mem_read_a  = issue && (gnt == G_CPU) && !cpu_we_q;
  assign mem_write   = issue && (gnt == G_CPU) && cpu_we_q;
  assign mem_read_b  = issue && (gnt == G_PPU);
  assign mem_refresh = issue && (gnt == G_REF);
  assign mem_addr    = (issue && gnt == G_CPU) ? cpu_addr_q :
                       (issue && gnt == G_PPU) ? ppu_addr_q : '0;
  assign mem_din     = mem_write ? cpu_din_q : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_pend   <= 1'b0;
      cpu_we_q   <= 1'b0;
      cpu_addr_q <= '0;
      cpu_din_q  <= '0;
      ppu_pend   <= 1'b0;
      ppu_addr_q <= '0;
      overrun    <= 1'b0;
    end else begin
      if (cpu_take) begin
        cpu_pend   <= 1'b1;
        cpu_we_q   <= cpu_we;
        cpu_addr_q <= cpu_addr;
        cpu_din_q  <= cpu_din;
      end else if (done && gnt == G_CPU) begin
        cpu_pend <= 1'b0;
      end
      if (ppu_take) begin
        ppu_pend   <= 1'b1;
        ppu_addr_q <= ppu_addr;
      end else if (done && gnt == G_PPU) begin
        ppu_pend <= 1'b0;
      end
      if ((cpu_req && cpu_pend) || (ppu_req && ppu_pend)) overrun <= 1'b1;
    end
  end

  // A tick coinciding with refresh completion counts as a fresh due event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_cnt  <= RELOAD;
      ref_pend <= 1'b0;
      defer    <= '0;
    end else begin
      ref_cnt <= ref_tick ? RELOAD : ref_cnt - 1'b1;
      if (ref_tick)                    ref_pend <= 1'b1;
      else if (done && gnt == G_REF)   ref_pend <= 1'b0;
      if (grant) begin
        if (gnt_nx == G_REF)               defer <= '0;
        else if (ref_pend && defer != DMAX) defer <= defer + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_ack  <= 1'b0;
      ppu_ack  <= 1'b0;
      cpu_dout <= 8'h00;
      ppu_dout <= 8'h00;
    end else begin
      cpu_ack <= done && (gnt == G_CPU);
      ppu_ack <= done && (gnt == G_PPU);
      if (done && gnt == G_CPU && !cpu_we_q) cpu_dout <= mem_dout_a;
      if (done && gnt == G_PPU)              ppu_dout <= mem_dout_b;
    end
  end

endmodule
